vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
// - Sequences the 640x480 VGA raster: pixel-rate divider, H/V scan counters, run/stop FSM.
// - Drives the H/V buses consumed by the sync decoder and the pixel/game renderers.
// - Also produces sync, active-video, line/frame strobes and a frame counter for game timing.
// - Sits between the board clock and all video consumers; one instance per display.
// PARAMETERS
// CLK_DIV   4    clk cycles per pixel; 1 means a tick every clk
// H_TOTAL   800  pixels per line, including blanking
// V_TOTAL   525  lines per frame, including blanking
// H_ACTIVE  640  visible pixels per line
// V_ACTIVE  480  visible lines per frame
// HS_START  655  first H value with Hsync low (inclusive)
// HS_END    750  last H value with Hsync low (inclusive)
// VS_START  489  first V value with Vsync low (inclusive)
// VS_END    490  last V value with Vsync low (inclusive)
// PORTS
// clk          in   1   system clock; all state changes on its rising edge
// rst          in   1   asynchronous, active-high reset
// run          in   1   level request: 1 = scan the raster, 0 = stop at end of frame
// H            out  16  current pixel column, 0..H_TOTAL-1
// V            out  16  current line, 0..V_TOTAL-1
// Hsync        out  1   active-low horizontal sync
// Vsync        out  1   active-low vertical sync
// active       out  1   high while (H,V) is inside the visible area
// pix_tick     out  1   one-clk strobe; the counters advance on the edge that ends this cycle
// line_start   out  1   pix_tick && H==0 && state!=IDLE
// frame_start  out  1   pix_tick && H==0 && V==0 && state!=IDLE
// frame_count  out  8   frames started since reset; wraps 255->0
// busy         out  1   state != IDLE
// BEHAVIOUR
// - Reset values: H=0, V=0, Hsync=1, Vsync=1, active=0, pix_tick=0,
//   line_start=0, frame_start=0, frame_count=0, busy=0, divider=0, FSM=IDLE.
// - FSM states:
//   IDLE: counters and divider held at 0. run=1 -> RUN on the next edge.
//   RUN: run=0 -> STOPPING.
//   STOPPING: run=1 -> RUN (stop cancelled, counters untouched).
//     A pix_tick at H=H_TOTAL-1 and V=V_TOTAL-1 -> IDLE, and the counters wrap to 0,0.
//     That frame-end transition has priority over run=1 in the same cycle.
// - Divider:
//   - Counts 0..CLK_DIV-1 in RUN/STOPPING; pix_tick=1 when divider==CLK_DIV-1.
//   - The divider is cleared on entering RUN from IDLE, so the first pix_tick falls on
//     the CLK_DIV-th clk in RUN. It is not cleared on STOPPING->RUN.
// - Counters:
//   - On pix_tick: if H==H_TOTAL-1, H<=0, else H<=H+1.
//   - V increments only when H wraps; when V==V_TOTAL-1 and H wraps, V<=0.
//   - All arithmetic is 16-bit unsigned. H and V never leave their ranges.
// - Decode: combinational from the registered H/V/state, so it aligns with H/V in the
//   same cycle (zero latency).
//   - Hsync = ~(busy && HS_START<=H<=HS_END)
//   - Vsync = ~(busy && VS_START<=V<=VS_END)
//   - active = busy && H<H_ACTIVE && V<V_ACTIVE
//   - In IDLE the syncs are high and active is low.
// - Strobes: line_start and frame_start are one-clk pulses, each coincident with a pix_tick.
//   frame_count increments on the edge ending a frame_start cycle.
// - Reset asserted mid-frame: every output returns to its reset value immediately
//   (asynchronous). Scanning resumes only after rst falls and run=1 is sampled.
// TESTING
// - Reset: rst=1 with run=1 -> H=V=0, Hsync=Vsync=1, active=0, busy=0, frame_count=0.
// - Start, CLK_DIV=4: run rises at edge 0 -> busy=1 after edge 1.
//   Strobes on the first tick in RUN (4th clk): pix_tick=line_start=frame_start=1.
//   Then pix_tick every 4 clks, and H reaches 1 after that tick.
// - Line timing:
//   - Hsync is low for exactly 96 ticks (H=655..750).
//   - active is high for 640 ticks per visible line.
//   - line_start repeats every 800 ticks (3200 clks).
// - Frame timing:
//   - Vsync is low for lines 489 and 490 only (1600 ticks).
//   - frame_start repeats every 420000 ticks; frame_count goes 0->1->2.
// - Stop: run=0 at H=100,V=200 -> scanning continues to H=799,V=524, then IDLE with
//   H=V=0, syncs high. run=0 then 1 mid-frame -> no gap, no IDLE.
// - Edge cases: rst pulse at H=700 (Hsync low) -> Hsync=1 and H=0 immediately.
//   With CLK_DIV=1: pix_tick is high every clk in RUN, and 256 frames wrap frame_count to 0.

Source files
------------

// File: rtl/vga_timing_ctrl_if.sv
// VGA raster bus: run request in, scan position, syncs and timing strobes out.
interface vga_timing_ctrl_if;
    logic        run;
    logic [15:0] H;
    logic [15:0] V;
    logic        Hsync;
    logic        Vsync;
    logic        active;
    logic        pix_tick;
    logic        line_start;
    logic        frame_start;
    logic [7:0]  frame_count;
    logic        busy;

    // The timing controller drives the raster; consumers request run and observe.
    modport master (
        input  run,
        output H, V, Hsync, Vsync, active, pix_tick,
        output line_start, frame_start, frame_count, busy
    );

    modport slave (
        output run,
        input  H, V, Hsync, Vsync, active, pix_tick,
        input  line_start, frame_start, frame_count, busy
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel-rate divider, H/V scan counters and a run/stop FSM
// that only halts on a frame boundary, with zero-latency sync/active decode.
module vga_timing_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int HS_START = 655,
    parameter int HS_END   = 750,
    parameter int VS_START = 489,
    parameter int VS_END   = 490
) (
    input  logic                clk,
    input  logic                rst,
    vga_timing_ctrl_if.master   vga
);

    // A divide-by-1 still needs a one-bit divider register.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [15:0]      h_cnt;
    logic [15:0]      v_cnt;
    logic [7:0]       frame_cnt;

    logic busy;
    logic tick;
    logic h_last;
    logic v_last;
    logic frame_end;
    logic frame_first;

    // Status terms decoded from the registered state and counters.
    always_comb begin
        busy        = (state != IDLE);
        tick        = busy && (div_cnt == DIV_W'(CLK_DIV - 1));
        h_last      = (h_cnt == 16'(H_TOTAL - 1));
        v_last      = (v_cnt == 16'(V_TOTAL - 1));
        frame_end   = tick && h_last && v_last;
        frame_first = tick && (h_cnt == 16'd0) && (v_cnt == 16'd0);
    end

    // Run/stop FSM with divider, scan counters and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            h_cnt     <= 16'd0;
            v_cnt     <= 16'd0;
            frame_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Holding the divider at zero makes the first tick land on
                    // the CLK_DIV-th clock after RUN is entered.
                    div_cnt <= '0;
                    h_cnt   <= 16'd0;
                    v_cnt   <= 16'd0;
                    if (vga.run) begin
                        state <= RUN;
                    end
                end
                RUN, STOPPING: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    if (tick) begin
                        h_cnt <= h_last ? 16'd0 : h_cnt + 16'd1;
                        if (h_last) begin
                            v_cnt <= v_last ? 16'd0 : v_cnt + 16'd1;
                        end
                    end
                    if (frame_first) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                    // Frame end wins over a re-request so a stop always lands on 0,0.
                    if (state == STOPPING && frame_end) begin
                        state <= IDLE;
                    end else if (state == RUN && !vga.run) begin
                        state <= STOPPING;
                    end else if (state == STOPPING && vga.run) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Zero-latency decode of syncs, visible area and strobes.
    always_comb begin
        vga.H           = h_cnt;
        vga.V           = v_cnt;
        vga.Hsync       = ~(busy && (h_cnt >= 16'(HS_START)) && (h_cnt <= 16'(HS_END)));
        vga.Vsync       = ~(busy && (v_cnt >= 16'(VS_START)) && (v_cnt <= 16'(VS_END)));
        vga.active      = busy && (h_cnt < 16'(H_ACTIVE)) && (v_cnt < 16'(V_ACTIVE));
        vga.pix_tick    = tick;
        vga.line_start  = tick && (h_cnt == 16'd0);
        vga.frame_start = frame_first;
        vga.frame_count = frame_cnt;
        vga.busy        = busy;
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: two reduced-geometry instances (CLK_DIV=4 and 1)
// checked every cycle against a position-from-clock-count model, plus literal pins.
module tb_vga_timing_ctrl;

    localparam int NI = 2;
    localparam int DIVS [NI] = '{4, 1};
    localparam int HT   [NI] = '{20, 8};
    localparam int VT   [NI] = '{10, 5};
    localparam int HA   [NI] = '{12, 5};
    localparam int VA   [NI] = '{7, 3};
    localparam int HS0  [NI] = '{14, 6};
    localparam int HS1  [NI] = '{16, 6};
    localparam int VS0  [NI] = '{8, 4};
    localparam int VS1  [NI] = '{8, 4};

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        act;
        logic        tick;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
        logic        busy;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run_s [NI];
    bit   chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    vga_timing_ctrl_if ia ();
    vga_timing_ctrl_if ib ();

    assign ia.run = run_s[0];
    assign ib.run = run_s[1];

    vga_timing_ctrl #(
        .CLK_DIV(DIVS[0]), .H_TOTAL(HT[0]), .V_TOTAL(VT[0]),
        .H_ACTIVE(HA[0]), .V_ACTIVE(VA[0]),
        .HS_START(HS0[0]), .HS_END(HS1[0]), .VS_START(VS0[0]), .VS_END(VS1[0])
    ) dut_a (.clk(clk), .rst(rst), .vga(ia));

    vga_timing_ctrl #(
        .CLK_DIV(DIVS[1]), .H_TOTAL(HT[1]), .V_TOTAL(VT[1]),
        .H_ACTIVE(HA[1]), .V_ACTIVE(VA[1]),
        .HS_START(HS0[1]), .HS_END(HS1[1]), .VS_START(VS0[1]), .VS_END(VS1[1])
    ) dut_b (.clk(clk), .rst(rst), .vga(ib));

    always #5 clk = ~clk;

    obs_t dut_o [NI];
    assign dut_o[0] = {ia.H, ia.V, ia.Hsync, ia.Vsync, ia.active, ia.pix_tick,
                       ia.line_start, ia.frame_start, ia.frame_count, ia.busy};
    assign dut_o[1] = {ib.H, ib.V, ib.Hsync, ib.Vsync, ib.active, ib.pix_tick,
                       ib.line_start, ib.frame_start, ib.frame_count, ib.busy};

    // Model: while scanning, the raster position is simply the number of
    // elapsed pixel periods since the session began, modulo the frame size.
    bit         m_busy [NI];
    bit         m_stop [NI];
    int         m_cyc  [NI];
    logic [7:0] m_fc   [NI];

    function automatic int m_pos(int i);
        return (m_cyc[i] / DIVS[i]) % (HT[i] * VT[i]);
    endfunction

    function automatic bit m_tick(int i);
        return m_busy[i] && ((m_cyc[i] % DIVS[i]) == DIVS[i] - 1);
    endfunction

    function automatic bit m_fs(int i);
        return m_tick(i) && (m_pos(i) == 0);
    endfunction

    function automatic obs_t m_out(int i);
        obs_t o;
        int   h;
        int   v;
        bit   b;
        b = m_busy[i];
        h = b ? m_pos(i) % HT[i] : 0;
        v = b ? m_pos(i) / HT[i] : 0;
        o.h    = 16'(h);
        o.v    = 16'(v);
        o.hs   = !(b && h >= HS0[i] && h <= HS1[i]);
        o.vs   = !(b && v >= VS0[i] && v <= VS1[i]);
        o.act  = b && h < HA[i] && v < VA[i];
        o.tick = m_tick(i);
        o.ls   = m_tick(i) && h == 0;
        o.fs   = m_fs(i);
        o.fc   = m_fc[i];
        o.busy = b;
        return o;
    endfunction

    // Model advance on each clock edge, or immediately on reset.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_busy[i] <= 1'b0;
                m_stop[i] <= 1'b0;
                m_cyc[i]  <= 0;
                m_fc[i]   <= 8'd0;
            end else if (!m_busy[i]) begin
                if (run_s[i]) begin
                    m_busy[i] <= 1'b1;
                    m_cyc[i]  <= 0;
                    m_stop[i] <= 1'b0;
                end
            end else begin
                if (m_fs(i)) m_fc[i] <= m_fc[i] + 8'd1;
                if (m_stop[i] && m_tick(i) && m_pos(i) == HT[i] * VT[i] - 1) begin
                    m_busy[i] <= 1'b0;
                    m_cyc[i]  <= 0;
                    m_stop[i] <= 1'b0;
                end else begin
                    m_cyc[i] <= m_cyc[i] + 1;
                    if (!m_stop[i] && !run_s[i]) m_stop[i] <= 1'b1;
                    else if (m_stop[i] && run_s[i]) m_stop[i] <= 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                n_tests++;
                if (dut_o[i] !== m_out(i)) begin
                    n_fail++;
                    if (n_fail <= 25)
                        $display("FAIL model_cmp[%0d] @%0t: got %h, expected %h",
                                 i, $time, dut_o[i], m_out(i));
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic seq_a();
        int clks, hsl, vsl, actn, lsn, lh, lv, lowcnt;
        bit seen;
        // Frame timing over one complete frame between consecutive frame_starts.
        seen = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (ia.frame_start) seen = 1;
        end
        check("a_wait_frame1", 32'(seen), 32'd1);
        clks = 0; hsl = 0; vsl = 0; actn = 0; lsn = 0;
        do begin
            if (ia.pix_tick) begin
                if (!ia.Hsync) hsl++;
                if (!ia.Vsync) vsl++;
                if (ia.active) actn++;
                if (ia.line_start) lsn++;
            end
            clks++;
            @(negedge clk);
        end while (!ia.frame_start && clks < 2000);
        check("a_frame_period_clks", 32'(clks), 32'd800);
        check("a_hsync_low_ticks", 32'(hsl), 32'd30);
        check("a_vsync_low_ticks", 32'(vsl), 32'd20);
        check("a_active_ticks", 32'(actn), 32'd84);
        check("a_lines_per_frame", 32'(lsn), 32'd10);
        check("a_frame_count_2", 32'(ia.frame_count), 32'd2);

        // Stop mid-frame: scanning must finish the frame, then go idle at 0,0.
        seen = 0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            if (ia.H == 16'd5 && ia.V == 16'd4) seen = 1;
        end
        check("a_reach_5_4", 32'(seen), 32'd1);
        @(posedge clk); #2; run_s[0] = 1'b0;
        seen = 0; lh = 0; lv = 0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            if (!ia.busy) seen = 1;
            else begin lh = int'(ia.H); lv = int'(ia.V); end
        end
        check("a_stop_reaches_idle", 32'(seen), 32'd1);
        check("a_last_h_before_idle", 32'(lh), 32'd19);
        check("a_last_v_before_idle", 32'(lv), 32'd9);
        check("a_idle_h", 32'(ia.H), 32'd0);
        check("a_idle_v", 32'(ia.V), 32'd0);
        check("a_idle_hsync", 32'(ia.Hsync), 32'd1);
        check("a_idle_vsync", 32'(ia.Vsync), 32'd1);

        // Stop request withdrawn mid-frame: no idle gap.
        @(posedge clk); #2; run_s[0] = 1'b1;
        repeat (300) @(posedge clk);
        #2; run_s[0] = 1'b0;
        @(posedge clk); #2; run_s[0] = 1'b1;
        lowcnt = 0;
        for (int c = 0; c < 1600; c++) begin
            @(negedge clk);
            if (!ia.busy) lowcnt++;
        end
        check("a_cancel_no_gap", 32'(lowcnt), 32'd0);

        // Random run toggling, checked by the per-cycle model comparison.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 99) < 3) run_s[0] = ~run_s[0];
        end
    endtask

    task automatic seq_b();
        int fs_n, notick;
        fs_n = 0; notick = 0;
        for (int c = 0; c < 12000 && fs_n < 255; c++) begin
            @(negedge clk);
            if (ib.busy && !ib.pix_tick) notick++;
            if (ib.frame_start) fs_n++;
        end
        check("b_frames_seen", 32'(fs_n), 32'd255);
        check("b_tick_every_clk", 32'(notick), 32'd0);
        check("b_frame_count_255", 32'(ib.frame_count), 32'd255);
        @(posedge clk); #1;
        check("b_frame_count_wrap", 32'(ib.frame_count), 32'd0);
    endtask

    initial begin
        bit seen;
        run_s[0] = 1'b1;
        run_s[1] = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_h", 32'(ia.H), 32'd0);
        check("rst_v", 32'(ia.V), 32'd0);
        check("rst_hsync", 32'(ia.Hsync), 32'd1);
        check("rst_vsync", 32'(ia.Vsync), 32'd1);
        check("rst_active", 32'(ia.active), 32'd0);
        check("rst_busy", 32'(ia.busy), 32'd0);
        check("rst_frame_count", 32'(ia.frame_count), 32'd0);
        chk_en = 1'b1;
        #1; rst = 1'b0;

        // Start: busy after the first edge, first tick on the 4th clk in RUN.
        @(posedge clk); #1;
        check("start_busy", 32'(ia.busy), 32'd1);
        check("start_no_tick", 32'(ia.pix_tick), 32'd0);
        check("b_start_tick", 32'(ib.pix_tick), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("first_tick", 32'(ia.pix_tick), 32'd1);
        check("first_line_start", 32'(ia.line_start), 32'd1);
        check("first_frame_start", 32'(ia.frame_start), 32'd1);
        check("first_tick_h", 32'(ia.H), 32'd0);
        @(posedge clk); #1;
        check("h_after_tick", 32'(ia.H), 32'd1);
        check("frame_count_1", 32'(ia.frame_count), 32'd1);

        fork
            seq_a();
            seq_b();
        join

        // Asynchronous reset while Hsync is low.
        run_s[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (!ia.Hsync) seen = 1;
        end
        check("a_reach_hsync_low", 32'(seen), 32'd1);
        #1; rst = 1'b1;
        #1;
        check("arst_hsync", 32'(ia.Hsync), 32'd1);
        check("arst_h", 32'(ia.H), 32'd0);
        check("arst_busy", 32'(ia.busy), 32'd0);
        check("arst_frame_count", 32'(ia.frame_count), 32'd0);
        run_s[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2; rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("arst_stays_idle", 32'(ia.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
